// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
`timescale 1ns/1ps
package bcd_to_binary_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BCD_DIGITS    = 2;
   localparam int BIN_W         = 7;
   localparam int NUM_ITERS     = 7;
   localparam int BCD_MAX_DIGIT = 9;

   // Work register: {tens, ones, bin}
   localparam int WORK_W = BCD_DIGITS * 4 + BIN_W;
   localparam int CNT_W  = 3;

   // True when a 4-bit value is a legal decimal digit.
   function automatic logic digit_legal(input logic [3:0] d);
      return d <= 4'(BCD_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_to_binary_seq_digit_sub3.sv
// Reverse double-dabble digit correction: take 3 off any digit that is 8 or more.
`timescale 1ns/1ps
module bcd_digit_sub3 (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Bit 3 set means the digit is 8..15; no borrow is possible there.
   always_comb begin
      digit_o = digit_i;
      if (digit_i[3]) digit_o = digit_i - 4'd3;
   end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Two-digit BCD to 7-bit binary, one reverse double-dabble shift per cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for digits; in_rdy high
// CALC  | shifting work register, 7 iterations
// DONE  | result presented with out_val; held until out_rdy
`timescale 1ns/1ps
module bcd_to_binary_seq
   import bcd_to_binary_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [3:0]       in_tens,
   input  logic [3:0]       in_ones,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [BIN_W-1:0] out_bin,
   output logic             out_err
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [WORK_W-1:0]   work_q, work_d;
   logic [BIN_W-1:0]    out_bin_q, out_bin_d;
   logic                err_q, err_d;

   logic [WORK_W-1:0]   shifted;
   logic [3:0]          tens_fix;
   logic [3:0]          ones_fix;
   logic [WORK_W-1:0]   work_step;

   // One iteration: shift right, BCD LSB drops into bin MSB, then fix each digit.
   assign shifted = work_q >> 1;

   bcd_digit_sub3 u_sub3_tens (
      .digit_i (shifted[WORK_W-1 -: 4]),
      .digit_o (tens_fix)
   );

   bcd_digit_sub3 u_sub3_ones (
      .digit_i (shifted[WORK_W-5 -: 4]),
      .digit_o (ones_fix)
   );

   assign work_step = {tens_fix, ones_fix, shifted[BIN_W-1:0]};

   // Next-state, counter, work register and result capture.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      out_bin_d = out_bin_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (in_val) begin
               if (digit_legal(in_tens) && digit_legal(in_ones)) begin
                  work_d  = {in_tens, in_ones, {BIN_W{1'b0}}};
                  cnt_d   = '0;
                  state_d = CALC;
               end else begin
                  out_bin_d = '0;
                  err_d     = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         CALC: begin
            work_d = work_step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(NUM_ITERS - 1)) begin
               out_bin_d = work_step[BIN_W-1:0];
               err_d     = 1'b0;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_rdy) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         out_bin_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         out_bin_q <= out_bin_d;
         err_q     <= err_d;
      end
   end

   assign in_rdy  = (state_q == IDLE) && !rst;
   assign out_val = (state_q == DONE);
   assign out_bin = out_bin_q;
   assign out_err = err_q;

endmodule
